// File: rtl/occupancy_pkg.sv
// Shared types and constants for the doorway occupancy counter.
package occupancy_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [1:0] SEL_ONES = 2'b01;
  localparam logic [1:0] SEL_TENS = 2'b10;

  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    IN1,
    IN2,
    IN3,
    OUT1,
    OUT2,
    OUT3
  } occ_state_e;

endpackage

// File: rtl/bcd_updown_sat.sv
// Two-digit BCD up/down counter that saturates at MAX going up and at 0 going down.
module bcd_updown_sat
  import occupancy_pkg::*;
#(
  parameter int unsigned MAX = 99
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic               full,
  output logic               empty
);

  localparam logic [DIGIT_W-1:0] MAX_TENS = DIGIT_W'(MAX / 10);
  localparam logic [DIGIT_W-1:0] MAX_ONES = DIGIT_W'(MAX % 10);

  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;

  assign full  = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
  assign empty = (tens_q == '0) && (ones_q == '0);

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (inc && !full) begin
      if (ones_q == 4'd9) begin
        ones_d = '0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (dec && !empty) begin
      if (ones_q == '0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/occupancy_bcd_counter.sv
// Doorway beam decoder with saturating BCD occupancy count and a two-digit display scan.
// Define OCC_BLANK_EN to blank a leading zero in the tens slot of digit_data.
module occupancy_bcd_counter
  import occupancy_pkg::*;
#(
  parameter int unsigned MAX_OCC  = 99,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sensor_a,
  input  logic               sensor_b,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic [DIGIT_W-1:0] digit_data,
  output logic [1:0]         digit_sel,
  output logic               full,
  output logic               empty,
  output logic               occupied
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  logic       a_meta, a_sync;
  logic       b_meta, b_sync;
  logic [1:0] ab;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_meta <= 1'b0;
      a_sync <= 1'b0;
      b_meta <= 1'b0;
      b_sync <= 1'b0;
    end else begin
      a_meta <= sensor_a;
      a_sync <= a_meta;
      b_meta <= sensor_b;
      b_sync <= b_meta;
    end
  end

  assign ab = {a_sync, b_sync};

  occ_state_e state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ab == 2'b10)      state_q <= IN1;
          else if (ab == 2'b01) state_q <= OUT1;
        end
        IN1: begin
          if (ab == 2'b11)      state_q <= IN2;
          else if (ab != 2'b10) state_q <= IDLE;
        end
        IN2: begin
          unique case (ab)
            2'b01:   state_q <= IN3;
            2'b10:   state_q <= IN1;
            2'b00:   state_q <= IDLE;
            default: state_q <= IN2;
          endcase
        end
        IN3: begin
          unique case (ab)
            2'b00, 2'b10: state_q <= IDLE;
            2'b11:        state_q <= IN2;
            default:      state_q <= IN3;
          endcase
        end
        OUT1: begin
          if (ab == 2'b11)      state_q <= OUT2;
          else if (ab != 2'b01) state_q <= IDLE;
        end
        OUT2: begin
          unique case (ab)
            2'b10:   state_q <= OUT3;
            2'b01:   state_q <= OUT1;
            2'b00:   state_q <= IDLE;
            default: state_q <= OUT2;
          endcase
        end
        OUT3: begin
          unique case (ab)
            2'b00, 2'b01: state_q <= IDLE;
            2'b11:        state_q <= OUT2;
            default:      state_q <= OUT3;
          endcase
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Decoded straight from the completing transition so the count moves on the same
  // edge that the FSM returns to IDLE.
  logic inc, dec;
  assign inc = (state_q == IN3)  && (ab == 2'b00);
  assign dec = (state_q == OUT3) && (ab == 2'b00);

  bcd_updown_sat #(
    .MAX (MAX_OCC)
  ) u_bcd (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .dec   (dec),
    .tens  (tens),
    .ones  (ones),
    .full  (full),
    .empty (empty)
  );

  assign occupied = !empty;

  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       sel_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      sel_q    <= SEL_ONES;
    end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      sel_q    <= (sel_q == SEL_ONES) ? SEL_TENS : SEL_ONES;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign digit_sel = sel_q;

  always_comb begin
    digit_data = (sel_q == SEL_TENS) ? tens : ones;
`ifdef OCC_BLANK_EN
    if ((sel_q == SEL_TENS) && (tens == '0)) digit_data = BLANK_CODE;
`else
`endif
  end

endmodule

// File: tb/tb_occupancy_bcd_counter.sv
// Randomized passage bench for occupancy_bcd_counter with a pattern-level occupancy model.
module tb_occupancy_bcd_counter;

  localparam int SCAN = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sensor_a = 1'b0;
  logic sensor_b = 1'b0;

  logic [3:0] tens_s, ones_s, dd_s;
  logic [1:0] sel_s;
  logic       full_s, empty_s, occ_s;
  logic [3:0] tens_b, ones_b, dd_b;
  logic [1:0] sel_b;
  logic       full_b, empty_b, occ_b;

  occupancy_bcd_counter #(.MAX_OCC(12), .SCAN_DIV(SCAN)) u_dut_sat (
    .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
    .tens(tens_s), .ones(ones_s), .digit_data(dd_s), .digit_sel(sel_s),
    .full(full_s), .empty(empty_s), .occupied(occ_s)
  );

  occupancy_bcd_counter #(.MAX_OCC(99), .SCAN_DIV(SCAN)) u_dut (
    .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
    .tens(tens_b), .ones(ones_b), .digit_data(dd_b), .digit_sel(sel_b),
    .full(full_b), .empty(empty_b), .occupied(occ_b)
  );

  always #5 clk = ~clk;

  // Clock edges since reset released; the scan slot is this divided by SCAN.
  int n_edges;
  always @(posedge clk or posedge reset) begin
    if (reset) n_edges <= 0;
    else       n_edges <= n_edges + 1;
  end

  int errors = 0;
  int checks = 0;
  int m12 = 0;
  int m99 = 0;

  // Passage catalogue: symbols (a,b) MSB-first, length, and net effect on occupancy.
  logic [15:0] pat_code [8];
  int          pat_len  [8];
  int          pat_eff  [8];

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] ab, input int hold);
    @(negedge clk);
    sensor_a = ab[1];
    sensor_b = ab[0];
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic check_counts(input string ph);
    check_eq({ph, " tens12"},  int'(tens_s),  m12 / 10);
    check_eq({ph, " ones12"},  int'(ones_s),  m12 % 10);
    check_eq({ph, " full12"},  int'(full_s),  int'(m12 == 12));
    check_eq({ph, " empty12"}, int'(empty_s), int'(m12 == 0));
    check_eq({ph, " occ12"},   int'(occ_s),   int'(m12 != 0));
    check_eq({ph, " tens99"},  int'(tens_b),  m99 / 10);
    check_eq({ph, " ones99"},  int'(ones_b),  m99 % 10);
    check_eq({ph, " full99"},  int'(full_b),  int'(m99 == 99));
    check_eq({ph, " empty99"}, int'(empty_b), int'(m99 == 0));
    check_eq({ph, " occ99"},   int'(occ_b),   int'(m99 != 0));
  endtask

  function automatic int sat_step(input int m, input int eff, input int max);
    if (eff > 0) return (m < max) ? m + 1 : m;
    if (eff < 0) return (m > 0) ? m - 1 : m;
    return m;
  endfunction

  function automatic int exp_data(input int m, input logic [1:0] sel);
    if (sel == 2'b01) return m % 10;
`ifdef OCC_BLANK_EN
    if (m / 10 == 0) return 15;
`else
`endif
    return m / 10;
  endfunction

  // Count must hold two edges after the final 00 and move on the third.
  task automatic run_pattern(input int idx, input int hmin, input int hmax);
    logic [15:0] code;
    int len;
    code = pat_code[idx];
    len  = pat_len[idx];
    for (int i = 0; i < len - 1; i++)
      drive(code[2*(len-1-i) +: 2], int'($urandom_range(hmax, hmin)));
    drive(2'b00, 1);
    repeat (2) @(negedge clk);
    check_counts($sformatf("pre p%0d", idx));
    m12 = sat_step(m12, pat_eff[idx], 12);
    m99 = sat_step(m99, pat_eff[idx], 99);
    @(negedge clk);
    check_counts($sformatf("post p%0d", idx));
  endtask

  task automatic scan_check(input string ph, input int cycles);
    logic [1:0] esel;
    repeat (cycles) begin
      @(negedge clk);
      esel = (((n_edges / SCAN) % 2) == 1) ? 2'b10 : 2'b01;
      check_eq({ph, " sel99"},  int'(sel_b), int'(esel));
      check_eq({ph, " data99"}, int'(dd_b),  exp_data(m99, esel));
      check_eq({ph, " sel12"},  int'(sel_s), int'(esel));
      check_eq({ph, " data12"}, int'(dd_s),  exp_data(m12, esel));
    end
  endtask

  task automatic check_reset_vals(input string ph);
    check_eq({ph, " sel"},   int'(sel_b),   1);
    check_eq({ph, " data"},  int'(dd_b),    0);
    check_eq({ph, " sel12"}, int'(sel_s),   1);
    check_eq({ph, " data12"}, int'(dd_s),   0);
    check_counts(ph);
  endtask

  initial begin
    pat_code = '{16'b10_11_01_00, 16'b01_11_10_00, 16'b10_00, 16'b10_11_01_10_00,
                 16'b10_11_10_11_01_11_01_00, 16'b01_00, 16'b01_11_01_11_10_00,
                 16'b01_11_10_01_00};
    pat_len  = '{4, 4, 2, 5, 8, 2, 6, 5};
    pat_eff  = '{1, -1, 0, 0, 1, 0, -1, 0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_reset_vals("reset");

    // Directed: slow enter, exit, aborts, exit from empty.
    run_pattern(0, 5, 5);
    run_pattern(1, 5, 5);
    run_pattern(2, 2, 2);
    run_pattern(3, 2, 2);
    run_pattern(1, 2, 2);

    for (int k = 0; k < 60; k++) run_pattern(int'($urandom_range(7, 0)), 1, 3);

    // Climb to 37 so the MAX_OCC=12 instance pins at full on the way.
    while (m99 != 37) run_pattern((m99 < 37) ? 0 : 1, 1, 2);
    check_eq("full held", int'(full_s), 1);
    scan_check("scan37", 16);

    while (m99 != 4) run_pattern((m99 < 4) ? 4 : 6, 1, 2);
    scan_check("scan4", 10);

    // Reset while parked in IN2; the tail of the passage must not count.
    drive(2'b10, 3);
    drive(2'b11, 3);
    @(negedge clk);
    reset = 1'b1;
    m12 = 0;
    m99 = 0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    drive(2'b01, 3);
    drive(2'b00, 1);
    repeat (4) @(negedge clk);
    check_counts("after rst");
    scan_check("scan0", 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/occupancy_bcd_counter.md
Name: occupancy_bcd_counter

Overview:
- Upstream of the room's seven-segment decoder.
- Watches two beam sensors at the doorway: outer beam A and inner beam B.
- Decodes the direction of each passage and keeps a saturating two-digit BCD occupancy count.
- Time-multiplexes the tens and ones digits onto one 4-bit digit bus, with digit-select strobes, for the single shared decoder.

Parameters:
- MAX_OCC, 99: saturation ceiling for the occupancy count; legal range 1..99.
- SCAN_DIV, 50000: clock cycles per digit slot in the display scan; must be ≥2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sensor_a  in  1  outer beam broken (1 = broken); asynchronous to clk
- sensor_b  in  1  inner beam broken (1 = broken); asynchronous to clk
- tens  out  4  BCD tens digit of the count
- ones  out  4  BCD ones digit of the count
- digit_data  out  4  currently scanned digit, feeds the decoder data input
- digit_sel  out  2  one-hot, active-high digit enable; 01 = ones, 10 = tens
- full  out  1  count == MAX_OCC
- empty  out  1  count == 0
- occupied  out  1  count != 0; drives room lighting

Behaviour:
- Reset (asynchronous, active-high) values:
  - tens = 0, ones = 0.
  - FSM in IDLE; synchroniser flops = 0.
  - Scan counter = 0; digit_sel = 01; digit_data = 0.
  - full = 0 (since MAX_OCC ≥ 1), empty = 1, occupied = 0.
- Reset asserted mid-passage discards the partial sequence and clears the count.
- Synchroniser: each sensor passes through 2 flops. The FSM acts only on the synchronised pair (a,b).
- FSM states: IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3.
- Transitions, written as input(a,b) -> next state:
  - IDLE: 10 -> IN1; 01 -> OUT1; 00 and 11 -> stay.
  - IN1: 11 -> IN2; 00 and 01 -> IDLE (abort); 10 -> stay.
  - IN2: 01 -> IN3; 10 -> IN1; 00 -> IDLE; 11 -> stay.
  - IN3: 00 -> IDLE with an increment; 11 -> IN2; 10 -> IDLE (abort); 01 -> stay.
  - OUT1..OUT3: mirror of IN1..IN3 with a and b swapped. OUT3 with 00 -> IDLE with a decrement.
- Count is held as two BCD digits; ones wraps 9 -> 0 with a carry/borrow into tens.
- Increment when count == MAX_OCC: no change (saturate). Decrement when count == 0: no change.
- At most one count update per passage; there are no simultaneous inc/dec requests.
- Latency: if both pins go low at edge k-1, then at edge k+2 the FSM returns to IDLE, tens/ones update, and full/empty/occupied update. Flags are combinational from the registered digits.
- Scan:
  - Free-running counter 0..SCAN_DIV-1.
  - At wrap (counter == SCAN_DIV-1), digit_sel toggles 01 <-> 10 on the next edge.
  - digit_data is combinational: ones when digit_sel = 01, tens when digit_sel = 10.
  - Scanning never stops, including during count updates.
- digit_data only ever carries 0..9, except under the optional feature below.

Optional Feature:
- Macro: OCC_BLANK_EN.
- When defined: leading-zero blanking. While tens == 0 and digit_sel == 10, digit_data = 4'hF, which the decoder's default case renders blank. The `tens` port itself is unaffected.
- When undefined: digit_data always equals the selected digit.

Decomposition:
- Package occupancy_pkg contains:
  - the FSM state enum (IDLE, IN1..IN3, OUT1..OUT3);
  - BCD digit width constant 4;
  - SEL_ONES = 2'b01, SEL_TENS = 2'b10;
  - BLANK_CODE = 4'hF.
- One sub-module: bcd_updown_sat, a two-digit BCD counter with inc/dec inputs, parameter MAX, and the saturation logic.
- The FSM, synchroniser and scan logic stay in the top module.

Test Plan:
- Reset, then hold pins at 00 for 10 cycles -> tens=0, ones=0, empty=1, occupied=0, digit_sel=01, digit_data=0.
- Enter sequence (a,b) 10,11,01,00, each held 5 cycles -> ones=1 exactly 3 edges after pins reach 00; occupied=1. Then an exit sequence 01,11,10,00 -> count 0, empty=1.
- Aborted passages 10 -> 00 and 10,11,01 -> 10 -> 00 -> count unchanged.
- With MAX_OCC=12: 9 enters -> tens=0, ones=9; 1 more -> tens=1, ones=0; 5 more -> 12, full=1 and held. From 0, an exit sequence -> stays 0.
- With SCAN_DIV=4 and count 37: digit_sel alternates every 4 cycles; digit_data = 7 under 01 and 3 under 10.
- With OCC_BLANK_EN and count 5: digit_data = 4'hF while digit_sel=10; without the macro, digit_data = 0.
- Assert reset mid-passage while in IN2 with count 4 -> outputs return to reset values immediately; the following 01,00 produces no increment.
